// File: rtl/axi_mem_slave.sv
// ---------------------------------------------------------------------------
// axi_mem_slave
//   AXI4 memory slave. It holds MEM_WORDS 32-bit words, and word index is
//   addr[31:2]. Reads and writes each have their own FSM, and each FSM holds
//   one burst at a time. There is no ordering between reads and writes.
//
//   A beat is legal when all of the following are true:
//     - its word index is below MEM_WORDS
//     - size is 3'b010 (4 bytes)
//     - burst is FIXED or INCR
//   An illegal beat reads back 0 with SLVERR. An illegal write beat is
//   dropped, and the burst then gets SLVERR on B.
//
//   Handshake rule, same on every channel: a transfer takes place on the
//   rising edge where valid and ready are both 1. The sender holds valid and
//   its payload stable until that edge. Ready never depends on valid.
//
// Ports
//   clk, rst_n         rising-edge clock, asynchronous active-low reset
//   axi_aw* / axi_w*   write address / write data channels
//   axi_b*             write response channel
//   axi_ar* / axi_r*   read address / read data channels
//   dbg_r_state        read FSM state  (0 = R_IDLE, 1 = R_BURST)
//   dbg_w_state        write FSM state (0 = W_IDLE, 1 = W_DATA, 2 = W_RESP)
// ---------------------------------------------------------------------------
module axi_mem_slave #(
  parameter int MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  axi_awid,
  input  logic [31:0] axi_awaddr,
  input  logic [7:0]  axi_awlen,
  input  logic [2:0]  axi_awsize,
  input  logic [1:0]  axi_awburst,
  input  logic        axi_awvalid,
  output logic        axi_awready,
  input  logic [31:0] axi_wdata,
  input  logic [3:0]  axi_wstrb,
  input  logic        axi_wlast,
  input  logic        axi_wvalid,
  output logic        axi_wready,
  output logic [3:0]  axi_bid,
  output logic [1:0]  axi_bresp,
  output logic        axi_bvalid,
  input  logic        axi_bready,
  input  logic [3:0]  axi_arid,
  input  logic [31:0] axi_araddr,
  input  logic [7:0]  axi_arlen,
  input  logic [2:0]  axi_arsize,
  input  logic [1:0]  axi_arburst,
  input  logic        axi_arvalid,
  output logic        axi_arready,
  output logic [3:0]  axi_rid,
  output logic [31:0] axi_rdata,
  output logic [1:0]  axi_rresp,
  output logic        axi_rlast,
  output logic        axi_rvalid,
  input  logic        axi_rready,
  output logic        dbg_r_state,
  output logic [1:0]  dbg_w_state
);

  localparam int          IW          = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [31:0] MEM_WORDS_U = 32'(MEM_WORDS);

  typedef enum logic {R_IDLE = 1'b0, R_BURST = 1'b1} r_state_t;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;

  function automatic logic beat_ok(input logic [31:0] addr, input logic [2:0] size,
                                   input logic [1:0] burst);
    return ({2'b00, addr[31:2]} < MEM_WORDS_U) && (size == 3'b010) && !burst[1];
  endfunction

  // Only INCR moves the address. FIXED stays put. WRAP and reserved bursts
  // also stay put, because every one of their beats is an error anyway.
  function automatic logic [31:0] addr_step(input logic [31:0] addr, input logic [1:0] burst);
    return (burst == 2'b01) ? addr + 32'd4 : addr;
  endfunction

  logic [31:0] mem [MEM_WORDS];

  // Goes high on the first clock edge after reset is released. It holds
  // both address readys low until then.
  logic run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run <= 1'b0;
    else        run <= 1'b1;
  end

  // ------------------------------------------------------------------ read
  r_state_t    r_state, r_state_n;
  logic [31:0] r_addr, r_addr_n;
  logic [7:0]  r_len, r_len_n, r_cnt, r_cnt_n;
  logic [3:0]  r_id, r_id_n;
  logic [1:0]  r_burst, r_burst_n;
  logic [2:0]  r_size, r_size_n;
  logic        r_ok;
  logic [IW-1:0] r_idx;

  assign r_ok  = beat_ok(r_addr, r_size, r_burst);
  assign r_idx = r_addr[IW+1:2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= R_IDLE;
      r_addr  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_id    <= '0;
      r_burst <= '0;
      r_size  <= '0;
    end else begin
      r_state <= r_state_n;
      r_addr  <= r_addr_n;
      r_len   <= r_len_n;
      r_cnt   <= r_cnt_n;
      r_id    <= r_id_n;
      r_burst <= r_burst_n;
      r_size  <= r_size_n;
    end
  end

  always_comb begin
    r_state_n   = r_state;
    r_addr_n    = r_addr;
    r_len_n     = r_len;
    r_cnt_n     = r_cnt;
    r_id_n      = r_id;
    r_burst_n   = r_burst;
    r_size_n    = r_size;
    axi_arready = 1'b0;
    axi_rvalid  = 1'b0;
    axi_rlast   = 1'b0;
    axi_rresp   = 2'b00;
    axi_rdata   = '0;
    case (r_state)
      R_IDLE: begin
        axi_arready = run;
        if (run && axi_arvalid) begin
          r_addr_n  = axi_araddr;
          r_len_n   = axi_arlen;
          r_id_n    = axi_arid;
          r_burst_n = axi_arburst;
          r_size_n  = axi_arsize;
          r_cnt_n   = '0;
          r_state_n = R_BURST;
        end
      end
      R_BURST: begin
        axi_rvalid = 1'b1;
        axi_rlast  = (r_cnt == r_len);
        axi_rresp  = r_ok ? 2'b00 : 2'b10;
        // Read is combinational from the array. A write to the same word
        // on the same edge is seen only on the following cycle.
        axi_rdata  = r_ok ? mem[r_idx] : '0;
        if (axi_rready) begin
          r_addr_n = addr_step(r_addr, r_burst);
          r_cnt_n  = r_cnt + 8'd1;
          if (r_cnt == r_len) r_state_n = R_IDLE;
        end
      end
      default: r_state_n = R_IDLE;
    endcase
  end

  assign axi_rid     = r_id;
  assign dbg_r_state = r_state;

  // ----------------------------------------------------------------- write
  w_state_t    w_state, w_state_n;
  logic [31:0] w_addr, w_addr_n;
  logic [7:0]  w_len, w_len_n, w_cnt, w_cnt_n;
  logic [3:0]  w_id, w_id_n;
  logic [1:0]  w_burst, w_burst_n;
  logic [2:0]  w_size, w_size_n;
  logic        w_err, w_err_n;
  logic        w_ok, w_we;
  logic [IW-1:0] w_idx;

  assign w_ok  = beat_ok(w_addr, w_size, w_burst);
  assign w_idx = w_addr[IW+1:2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state <= W_IDLE;
      w_addr  <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      w_id    <= '0;
      w_burst <= '0;
      w_size  <= '0;
      w_err   <= 1'b0;
    end else begin
      w_state <= w_state_n;
      w_addr  <= w_addr_n;
      w_len   <= w_len_n;
      w_cnt   <= w_cnt_n;
      w_id    <= w_id_n;
      w_burst <= w_burst_n;
      w_size  <= w_size_n;
      w_err   <= w_err_n;
    end
  end

  always_comb begin
    w_state_n   = w_state;
    w_addr_n    = w_addr;
    w_len_n     = w_len;
    w_cnt_n     = w_cnt;
    w_id_n      = w_id;
    w_burst_n   = w_burst;
    w_size_n    = w_size;
    w_err_n     = w_err;
    w_we        = 1'b0;
    axi_awready = 1'b0;
    axi_wready  = 1'b0;
    axi_bvalid  = 1'b0;
    axi_bresp   = 2'b00;
    case (w_state)
      W_IDLE: begin
        axi_awready = run;
        if (run && axi_awvalid) begin
          w_addr_n  = axi_awaddr;
          w_len_n   = axi_awlen;
          w_id_n    = axi_awid;
          w_burst_n = axi_awburst;
          w_size_n  = axi_awsize;
          w_cnt_n   = '0;
          w_err_n   = 1'b0;
          w_state_n = W_DATA;
        end
      end
      W_DATA: begin
        axi_wready = 1'b1;
        if (axi_wvalid) begin
          w_we     = w_ok;
          w_addr_n = addr_step(w_addr, w_burst);
          w_cnt_n  = w_cnt + 8'd1;
          // The burst is an error if any beat is illegal, or if wlast
          // arrives at a beat count other than the length given on AW.
          w_err_n  = w_err | ~w_ok | (axi_wlast && (w_cnt != w_len));
          if (axi_wlast) w_state_n = W_RESP;
        end
      end
      W_RESP: begin
        axi_bvalid = 1'b1;
        axi_bresp  = w_err ? 2'b10 : 2'b00;
        if (axi_bready) w_state_n = W_IDLE;
      end
      default: w_state_n = W_IDLE;
    endcase
  end

  assign axi_bid     = w_id;
  assign dbg_w_state = w_state;

  // Memory contents survive reset, so this block has no reset.
  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int b = 0; b < 4; b++) begin
        if (axi_wstrb[b]) mem[w_idx][8*b +: 8] <= axi_wdata[8*b +: 8];
      end
    end
  end

endmodule
